// File: rtl/sort_controller_if.sv
// Command/status bundle for sort_controller: load, clear, start, read port and sort status.
interface sort_controller_if #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1),
   parameter int AW    = $clog2(DEPTH)
);
   logic            wr_en;
   logic [SIZE-1:0] wr_data;
   logic            clr;
   logic            start;
   logic [AW-1:0]   rd_addr;
   logic [SIZE-1:0] rd_data;
   logic [CW-1:0]   count;
   logic            full;
   logic            busy;
   logic            done;
   logic [15:0]     swap_count;

   modport master (
      output wr_en, wr_data, clr, start, rd_addr,
      input  rd_data, count, full, busy, done, swap_count
   );

   modport slave (
      input  wr_en, wr_data, clr, start, rd_addr,
      output rd_data, count, full, busy, done, swap_count
   );
endinterface

// File: rtl/sort_controller.sv
// In-place ascending bubble sort over a small buffer, one comparison per clock through a
// single shared unsigned comparator; early exit when a full pass makes no swap.
module comparator #(
   parameter int SIZE = 8
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            a_larger,
   output logic            equal
);
   assign a_larger = (a > b);
   assign equal    = (a == b);
endmodule

module sort_controller #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH + 1),
   parameter int AW    = $clog2(DEPTH)
) (
   input logic               clk,
   input logic               rst,
   sort_controller_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t          state;
   logic [SIZE-1:0] mem [DEPTH];
   logic [CW-1:0]   count;
   logic [CW-1:0]   limit;
   logic [AW-1:0]   j;
   logic            swapped;
   logic            full;
   logic            busy;
   logic            done;
   logic [15:0]     swap_count;
   logic [SIZE-1:0] rd_data;

   logic [AW-1:0]   j_nxt;
   logic [SIZE-1:0] cmp_a;
   logic [SIZE-1:0] cmp_b;
   logic            a_larger;
   logic            equal;
   logic            do_swap;
   logic            pass_end;
   logic            load;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign j_nxt = j + AW'(1);
   assign cmp_a = mem[j];
   assign cmp_b = mem[j_nxt];

   comparator #(.SIZE(SIZE)) u_cmp (
      .a        (cmp_a),
      .b        (cmp_b),
      .a_larger (a_larger),
      .equal    (equal)
   );

   // Equal keys never swap, which keeps the sort stable.
   assign do_swap  = (state == CMP) && a_larger && !equal;
   assign pass_end = (CW'(j) == limit - CW'(2));
   assign load     = (state == IDLE) && bus.wr_en && !bus.clr && !bus.start && !full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         limit      <= '0;
         j          <= '0;
         swapped    <= 1'b0;
         full       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         swap_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.clr) begin
                  count <= '0;
                  full  <= 1'b0;
               end else if (bus.start) begin
                  j          <= '0;
                  limit      <= count;
                  swapped    <= 1'b0;
                  swap_count <= '0;
                  busy       <= 1'b1;
                  if (count >= CW'(2)) begin
                     state <= CMP;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else if (bus.wr_en && !full) begin
                  count <= count + CW'(1);
                  full  <= (count + CW'(1) == CW'(DEPTH));
               end
            end
            CMP: begin
               if (do_swap) begin
                  swapped    <= 1'b1;
                  swap_count <= sat_inc(swap_count);
               end
               if (!pass_end) begin
                  j <= j_nxt;
               end else if (!(swapped || do_swap) || limit == CW'(2)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  // Largest remaining key has bubbled to the end; shrink the window.
                  limit   <= limit - CW'(1);
                  j       <= '0;
                  swapped <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         mem[count[AW-1:0]] <= bus.wr_data;
      end else if (do_swap) begin
         mem[j]     <= cmp_b;
         mem[j_nxt] <= cmp_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[bus.rd_addr];
   end

   assign bus.rd_data    = rd_data;
   assign bus.count      = count;
   assign bus.full       = full;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.swap_count = swap_count;
endmodule
